// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory responder: config-register offsets,
// TX FIFO geometry, TXSTAT bit layout and a couple of decode helpers.
package data_mem_pkg;

  localparam logic [15:0] CONF_LED    = 16'h0000;
  localparam logic [15:0] CONF_SWITCH = 16'h0004;
  localparam logic [15:0] CONF_TIMER  = 16'h0008;
  localparam logic [15:0] CONF_TXDATA = 16'h0010;
  localparam logic [15:0] CONF_TXSTAT = 16'h0014;

  localparam int TX_DEPTH = 4;
  localparam int TX_PTR_W = $clog2(TX_DEPTH);
  localparam int TX_CNT_W = TX_PTR_W + 1;

  localparam int TXSTAT_FULL_BIT  = 0;
  localparam int TXSTAT_EMPTY_BIT = 1;
  localparam int TXSTAT_CNT_LSB   = 2;
  localparam int TXSTAT_OVF_BIT   = 5;

  typedef enum logic [2:0] {
    REG_LED,
    REG_SWITCH,
    REG_TIMER,
    REG_TXDATA,
    REG_TXSTAT,
    REG_NONE
  } conf_reg_e;

  function automatic conf_reg_e conf_decode(input logic [15:0] off);
    case (off)
      CONF_LED:    return REG_LED;
      CONF_SWITCH: return REG_SWITCH;
      CONF_TIMER:  return REG_TIMER;
      CONF_TXDATA: return REG_TXDATA;
      CONF_TXSTAT: return REG_TXSTAT;
      default:     return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] txstat_pack(input logic ovf, input logic [TX_CNT_W-1:0] cnt,
                                              input logic empty, input logic full);
    logic [31:0] v;
    v = '0;
    v[TXSTAT_OVF_BIT]                = ovf;
    v[TXSTAT_CNT_LSB +: TX_CNT_W]    = cnt;
    v[TXSTAT_EMPTY_BIT]              = empty;
    v[TXSTAT_FULL_BIT]               = full;
    return v;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small byte FIFO feeding the TX stream. Pushes when full and pops when empty
// are silently ignored; storage is not reset, only pointers and count.
module tx_fifo
  import data_mem_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                push_i,
  input  logic [7:0]          din_i,
  input  logic                pop_i,
  output logic [TX_CNT_W-1:0] count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [7:0]          head_o
);

  logic [7:0]          mem_q [TX_DEPTH];
  logic [TX_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [TX_CNT_W-1:0] count_q;
  logic                do_push, do_pop;

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop
  // never makes room for a push into a full FIFO.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign count_o = count_q;
  assign full_o  = (count_q == TX_CNT_W'(TX_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + TX_PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + TX_PTR_W'(1);
      count_q <= count_q + TX_CNT_W'(do_push) - TX_CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/data_mem_resp.sv
// Data-side memory responder: word RAM with byte enables plus a small config
// region (LED, switches, free-running timer, TX byte FIFO) with 1-cycle reads.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] CONF_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  logic [31:0]         mem_q [0:(1<<RAM_AW)-1];
  logic [31:0]         ram_rdata_q, conf_rdata_q, conf_rdata;
  logic [31:0]         timer_q, timer_d;
  logic [15:0]         led_q, led_d;
  logic                ovf_q, ovf_d, rd_conf_q;
  logic                acc, is_conf, is_wr, conf_rd, conf_wr, ram_rd, ram_wr;
  logic [RAM_AW-1:0]   ram_idx;
  conf_reg_e           conf_sel;
  logic                push_req, pop;
  logic                fifo_full, fifo_empty;
  logic [TX_CNT_W-1:0] fifo_count;
  logic                unused_addr;

  assign unused_addr = ^addr[1:0];

  // Nothing is accepted while resetn is low, so reset can never be masked.
  assign acc      = en & resetn;
  assign is_conf  = (addr[31:16] == CONF_HI);
  assign is_wr    = |we;
  assign conf_sel = conf_decode(addr[15:0]);
  assign ram_idx  = addr[RAM_AW+1:2];
  assign conf_rd  = acc & is_conf & ~is_wr;
  assign conf_wr  = acc & is_conf & is_wr;
  assign ram_rd   = acc & ~is_conf & ~is_wr;
  assign ram_wr   = acc & ~is_conf & is_wr;

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem_q[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (ram_rd) ram_rdata_q <= mem_q[ram_idx];
  end

  // TX stream: a byte transfers on every rising edge where tx_valid and
  // tx_ready are both high; tx_valid never depends on tx_ready and tx_data
  // stays stable until the transfer happens.
  assign push_req = conf_wr & (conf_sel == REG_TXDATA) & we[0];
  assign pop      = tx_valid & tx_ready;
  assign tx_valid = ~fifo_empty;

  tx_fifo u_tx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_req),
    .din_i   (wdata[7:0]),
    .pop_i   (pop),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (tx_data)
  );

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (conf_wr && conf_sel == REG_TIMER) timer_d = wdata;

    led_d = led_q;
    if (conf_wr && conf_sel == REG_LED) begin
      if (we[0]) led_d[7:0]  = wdata[7:0];
      if (we[1]) led_d[15:8] = wdata[15:8];
    end

    // An overflowing push sets OVF even if a clear lands in the same cycle.
    ovf_d = ovf_q;
    if (conf_wr && conf_sel == REG_TXSTAT && we[0] && wdata[TXSTAT_OVF_BIT]) ovf_d = 1'b0;
    if (push_req && fifo_full) ovf_d = 1'b1;

    conf_rdata = '0;
    case (conf_sel)
      REG_LED:    conf_rdata = {16'h0, led_q};
      REG_SWITCH: conf_rdata = {16'h0, switch};
      REG_TIMER:  conf_rdata = timer_q;
      REG_TXSTAT: conf_rdata = txstat_pack(ovf_q, fifo_count, fifo_empty, fifo_full);
      default:    conf_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer_q      <= '0;
      led_q        <= '0;
      ovf_q        <= 1'b0;
      rd_conf_q    <= 1'b1;
      conf_rdata_q <= '0;
    end else begin
      timer_q <= timer_d;
      led_q   <= led_d;
      ovf_q   <= ovf_d;
      if (conf_rd) begin
        conf_rdata_q <= conf_rdata;
        rd_conf_q    <= 1'b1;
      end else if (ram_rd) begin
        rd_conf_q <= 1'b0;
      end
    end
  end

  // rd_conf_q resets high so rdata reads the zeroed conf register after reset.
  assign rdata = rd_conf_q ? conf_rdata_q : ram_rdata_q;
  assign led   = led_q;

endmodule
